audio_sample_scheduler: RTL
===========================

// Module: audio_sample_scheduler
// PURPOSE
//  Sits between the UART sample receiver and the audio DAC/PWM stage. Buffers incoming
//  16-bit samples in a FIFO and releases them at a fixed sample rate. Sequences playback
//  through prefill, play and underrun recovery, and raises host flow control from FIFO level.
// PARAMETERS
//  SAMPLE_DIV  612  clk cycles per output sample (27 MHz / 612 = 44.1 kHz); >= 4
//  ADDR_W      8    FIFO address width; DEPTH = 2**ADDR_W entries of 16 bits
//  PREFILL     128  FIFO level needed to leave FILL and enter PLAY; 1..DEPTH
//  HIGH_WATER  224  level at or above which rx_hold asserts
//  LOW_WATER   64   level at or below which rx_hold deasserts; LOW_WATER < HIGH_WATER
// PORTS
//  clk           in   1         system clock
//  rst           in   1         asynchronous active-high reset
//  stream_en     in   1         1 = run scheduler; 0 = stop and flush
//  rx_sample     in   16        sample from UART receiver (two's complement)
//  rx_valid      in   1         sample-ready strobe; only its rising edge is used
//  sample_out    out  16        sample to DAC; two's complement; 0 = silence
//  sample_strobe out  1         1-cycle pulse, one per sample period, sample_out valid
//  playing       out  1         1 while state == PLAY
//  rx_hold       out  1         flow control to host; 1 = pause sending
//  fifo_level    out  ADDR_W+1  current FIFO occupancy, 0..DEPTH
//  underrun_cnt  out  8         saturating count of underruns
//  overflow_cnt  out  8         saturating count of dropped samples
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, state STOP, tick counter 0, rx_valid edge register 0.
//  Push: happens on the cycle after rx_valid goes 0->1. A multi-cycle high counts once.
//    Push is accepted if fifo_level < DEPTH, or if a pop occurs in the same cycle.
//    Otherwise the sample is dropped and overflow_cnt increments, saturating at 255.
//    Push is ignored entirely in STOP.
//  Tick: counter runs freely 0..SAMPLE_DIV-1 in every state. tick = (count == SAMPLE_DIV-1).
//  Output: on the cycle after every tick, sample_strobe = 1 and sample_out updates. Latency is 1 clk.
//    STOP/FILL: sample_out = 0.
//    PLAY with FIFO non-empty: pop the head and present it.
//    PLAY with FIFO empty: sample_out = 0 and underrun handling applies.
//  State machine:
//    STOP: FIFO flushed (level = 0). Enter FILL when stream_en = 1.
//    FILL: collect samples. Enter PLAY at the first tick where level >= PREFILL.
//      That tick already pops.
//    PLAY: pop one sample per tick. At a tick with level == 0, enter FILL,
//      increment underrun_cnt (saturating at 255) and output 0.
//      A push in that same cycle is still written, but does not prevent the underrun.
//    Any state with stream_en = 0: next cycle goes to STOP, flushes the FIFO and clears rx_hold.
//      Counters hold their values.
//  Level: fifo_level is +1 on push only, -1 on pop only, and unchanged on both or neither.
//    Pointers wrap modulo DEPTH.
//  rx_hold is registered with hysteresis:
//    it sets when the next level >= HIGH_WATER;
//    it clears when the next level <= LOW_WATER;
//    otherwise it holds.
//  Counters are cleared only by rst.
//  Async rst mid-playback: outputs drop to 0 immediately; no strobe until the first tick after release.
// TESTING  (bench params: SAMPLE_DIV=8, ADDR_W=3, PREFILL=4, HIGH_WATER=6, LOW_WATER=2)
//  1 Prefill/play: en=1, push 0x0001..0x0004.
//    -> playing=1 at next tick; strobes output 1,2,3,4 spaced 8 clk; then 0 with underrun_cnt=1, playing=0.
//  2 Edge detect: hold rx_valid high 5 clk with 0x1234 -> fifo_level=1, not 5.
//  3 Overflow: in FILL with PREFILL set to 8, push 10 samples before a tick
//    -> level=8, overflow_cnt=2, first 8 samples retained in order.
//  4 Flow control: push 6 -> rx_hold=1. Drain to level 2 -> rx_hold=0. At level 3 (falling) -> still 1.
//  5 Push+pop same cycle in PLAY at level 8 (full) -> push accepted, level stays 8, overflow_cnt unchanged.
//  6 Flush/reset: en=0 in PLAY at level 5 -> next clk level=0, state STOP, sample_out=0.
//    rst mid-play -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/audio_sample_scheduler_if.sv
// Sample-stream bundle between the UART sample receiver/host side and the playback scheduler.
// Latency: none, this is wiring only.
// Backpressure: rx_hold is the only flow control back toward the sample source.
interface audio_sample_scheduler_if #(
    parameter int ADDR_W = 8
);
    logic              stream_en;
    logic [15:0]       rx_sample;
    logic              rx_valid;
    logic [15:0]       sample_out;
    logic              sample_strobe;
    logic              playing;
    logic              rx_hold;
    logic [ADDR_W:0]   fifo_level;
    logic [7:0]        underrun_cnt;
    logic [7:0]        overflow_cnt;

    // Source / observer side: drives control and samples, watches playback status.
    modport master (
        output stream_en,
        output rx_sample,
        output rx_valid,
        input  sample_out,
        input  sample_strobe,
        input  playing,
        input  rx_hold,
        input  fifo_level,
        input  underrun_cnt,
        input  overflow_cnt
    );

    // Scheduler side.
    modport slave (
        input  stream_en,
        input  rx_sample,
        input  rx_valid,
        output sample_out,
        output sample_strobe,
        output playing,
        output rx_hold,
        output fifo_level,
        output underrun_cnt,
        output overflow_cnt
    );
endinterface

// File: rtl/audio_sample_scheduler.sv
// Buffers received audio samples in a FIFO and releases one per sample period (STOP/FILL/PLAY).
// Latency: sample_out/sample_strobe appear 1 clk after the internal tick; a push lands 1 clk after rx_valid rises.
// Backpressure: none toward the DAC; the host is paused via rx_hold (hysteresis), excess pushes are dropped and counted.
module audio_sample_scheduler #(
    parameter int SAMPLE_DIV = 612,
    parameter int ADDR_W     = 8,
    parameter int PREFILL    = 128,
    parameter int HIGH_WATER = 224,
    parameter int LOW_WATER  = 64
) (
    input  logic clk,
    input  logic rst,
    audio_sample_scheduler_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int LVL_W = ADDR_W + 1;
    localparam int CNT_W = $clog2(SAMPLE_DIV);

    localparam logic [LVL_W-1:0] LVL_FULL    = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_PREFILL = LVL_W'(PREFILL);
    localparam logic [LVL_W-1:0] LVL_HIGH    = LVL_W'(HIGH_WATER);
    localparam logic [LVL_W-1:0] LVL_LOW     = LVL_W'(LOW_WATER);
    localparam logic [CNT_W-1:0] TICK_LAST   = CNT_W'(SAMPLE_DIV - 1);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_FILL = 2'd1,
        ST_PLAY = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   tick_cnt;
    logic               rx_valid_q;
    logic [15:0]        mem [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]   level;
    logic [15:0]        sample_out_q;
    logic               strobe_q;
    logic               playing_q;
    logic               rx_hold_q;
    logic [7:0]         underrun_q;
    logic [7:0]         overflow_q;

    logic               tick;
    logic               rx_rise;
    logic               push_req;
    logic               push;
    logic               pop;
    logic               drop;
    logic [LVL_W-1:0]   level_nxt;

    // Per-cycle decisions: tick, push/pop acceptance and the resulting FIFO level.
    always_comb begin
        tick     = (tick_cnt == TICK_LAST);
        rx_rise  = bus.rx_valid && !rx_valid_q;
        push_req = bus.stream_en && rx_rise && (state != ST_STOP);
        pop      = 1'b0;
        if (bus.stream_en && tick) begin
            case (state)
                ST_FILL: pop = (level >= LVL_PREFILL);
                ST_PLAY: pop = (level != '0);
                default: pop = 1'b0;
            endcase
        end
        // A full FIFO still takes the push when the same cycle frees a slot.
        push      = push_req && ((level != LVL_FULL) || pop);
        drop      = push_req && !push;
        level_nxt = level + LVL_W'(push) - LVL_W'(pop);
    end

    // Sample storage; no reset needed since level/pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.rx_sample;
        end
    end

    // Playback sequencer, FIFO bookkeeping, flow control and saturating counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_STOP;
            tick_cnt     <= '0;
            rx_valid_q   <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            sample_out_q <= '0;
            strobe_q     <= 1'b0;
            playing_q    <= 1'b0;
            rx_hold_q    <= 1'b0;
            underrun_q   <= '0;
            overflow_q   <= '0;
        end else begin
            tick_cnt   <= tick ? '0 : tick_cnt + CNT_W'(1);
            rx_valid_q <= bus.rx_valid;
            strobe_q   <= tick;

            if (drop && (overflow_q != 8'hFF)) begin
                overflow_q <= overflow_q + 8'd1;
            end

            if (!bus.stream_en) begin
                // Stopping discards everything buffered and silences the output.
                state        <= ST_STOP;
                playing_q    <= 1'b0;
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                level        <= '0;
                rx_hold_q    <= 1'b0;
                sample_out_q <= '0;
            end else begin
                level <= level_nxt;
                if (push) begin
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + ADDR_W'(1);
                end

                if (level_nxt >= LVL_HIGH) begin
                    rx_hold_q <= 1'b1;
                end else if (level_nxt <= LVL_LOW) begin
                    rx_hold_q <= 1'b0;
                end

                case (state)
                    ST_STOP: begin
                        state <= ST_FILL;
                        if (tick) begin
                            sample_out_q <= '0;
                        end
                    end
                    ST_FILL: begin
                        if (tick) begin
                            if (pop) begin
                                // The tick that ends prefill already plays the head sample.
                                state        <= ST_PLAY;
                                playing_q    <= 1'b1;
                                sample_out_q <= mem[rd_ptr];
                            end else begin
                                sample_out_q <= '0;
                            end
                        end
                    end
                    ST_PLAY: begin
                        if (tick) begin
                            if (pop) begin
                                sample_out_q <= mem[rd_ptr];
                            end else begin
                                // Ran dry: emit silence and rebuild the prefill cushion.
                                state        <= ST_FILL;
                                playing_q    <= 1'b0;
                                sample_out_q <= '0;
                                if (underrun_q != 8'hFF) begin
                                    underrun_q <= underrun_q + 8'd1;
                                end
                            end
                        end
                    end
                    default: begin
                        state     <= ST_STOP;
                        playing_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.sample_out    = sample_out_q;
    assign bus.sample_strobe = strobe_q;
    assign bus.playing       = playing_q;
    assign bus.rx_hold       = rx_hold_q;
    assign bus.fifo_level    = level;
    assign bus.underrun_cnt  = underrun_q;
    assign bus.overflow_cnt  = overflow_q;

endmodule
